// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets P_REQ_NUM byte streams share one UART
// transmitter, holding the grant for a whole packet and revoking it after an idle timeout.
`default_nettype none

module uart_tx_arb #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_TIMEOUT_CYCLE   = 1024
) (
  input  logic                                   i_sys_clk,
  input  logic                                   i_sys_rst,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy
);

  localparam int IW = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
  localparam int CW = (P_TIMEOUT_CYCLE > 1) ? $clog2(P_TIMEOUT_CYCLE) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(P_REQ_NUM - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(P_TIMEOUT_CYCLE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [CW-1:0]   idle_cnt;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [P_REQ_NUM-1:0] win_onehot;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 beat;
  logic                 drop_grant;

  // Round-robin search starting just after the previous owner, wrapping once.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= P_REQ_NUM; i++) begin
      cand = int'(last_owner) + i;
      if (cand >= P_REQ_NUM) cand = cand - P_REQ_NUM;
      cand_idx = IW'(cand);
      if (!win_found && i_req_valid[cand_idx]) begin
        win_found            = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

  // The owner path is a one-hot mux on o_grant, so everything collapses to zero in IDLE.
  always_comb begin
    o_tx_data = '0;
    for (int k = 0; k < P_REQ_NUM; k++) begin
      if (o_grant[k]) o_tx_data = o_tx_data | i_req_data[k*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
    end
  end

  assign owner_valid = |(o_grant & i_req_valid);
  assign owner_last  = |(o_grant & i_req_last);
  assign o_tx_valid  = owner_valid;
  assign o_req_ready = o_grant & {P_REQ_NUM{i_tx_ready}};
  assign beat        = owner_valid & i_tx_ready;
  assign drop_grant  = (state == XFER) &&
                       ((beat && owner_last) || (!owner_valid && (idle_cnt == CNT_MAX)));

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      owner      <= '0;
      last_owner <= LAST_INIT;
      idle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= XFER;
            o_grant  <= win_onehot;
            o_busy   <= 1'b1;
            owner    <= win_idx;
            idle_cnt <= '0;
          end
        end
        XFER: begin
          if (drop_grant) begin
            state      <= IDLE;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            last_owner <= owner;
            idle_cnt   <= '0;
          end else if (owner_valid) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: vector table plus scoreboard-driven packet sequences for uart_tx_arb.
`default_nettype none

module tb_uart_tx_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  uart_tx_arb #(
    .P_REQ_NUM(N),
    .P_UART_DATA_WIDTH(W),
    .P_TIMEOUT_CYCLE(T)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .i_req_data(req_data),
    .i_req_valid(req_valid),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_grant(grant),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        txr;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_busy;
  } vec_t;
  vec_t vt[8];

  logic [7:0] rbytes[N][16];
  logic       rlast[N][16];
  int         rlen[N];
  int         rpos[N];
  logic [N-1:0] stall;

  logic [N-1:0] g_s;
  logic [N-1:0] r_s;
  logic         b_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_sample();
    exp_t e;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_beat: got data %0h, expected no beat at %0t", tx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", tx_data, e.data);
        check("sb_owner", grant, 32'(1) << e.src);
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (!stall[k] && rpos[k] < rlen[k]) begin
        req_valid[k]        = 1'b1;
        req_data[k*W +: W]  = rbytes[k][rpos[k]];
        req_last[k]         = rlast[k][rpos[k]];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[k*W +: W]  = '0;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    g_s = grant;
    r_s = req_ready;
    b_s = busy;
    hs  = req_valid & req_ready;
    sb_sample();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) rpos[k]++;
    drive();
  endtask

  task automatic load_pkt(input int k, input logic [7:0] base, input int len, input bit push);
    for (int j = 0; j < len; j++) begin
      rbytes[k][rlen[k]+j] = base + 8'(j);
      rlast[k][rlen[k]+j]  = (j == len - 1);
      if (push) exp_q.push_back('{k, base + 8'(j)});
    end
    rlen[k] += len;
  endtask

  task automatic clear_bench();
    exp_q.delete();
    stall = '0;
    for (int k = 0; k < N; k++) begin
      rlen[k] = 0;
      rpos[k] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_ready = 1'b1;
    clear_bench();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    logic [N-1:0] exp_g;

    // Multi-requester table: tx_ready toggling on requester 2, other valid ignored.
    vt[0] = '{4'b0100, 4'b0000, 32'h00A5_0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vt[1] = '{4'b0100, 4'b0000, 32'h00A5_0011, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5, 1'b1};
    vt[2] = '{4'b0101, 4'b0100, 32'h005A_0011, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'h5A, 1'b1};
    vt[3] = '{4'b0101, 4'b0100, 32'h005A_0011, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h5A, 1'b1};
    vt[4] = '{4'b0001, 4'b0000, 32'h0000_0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vt[5] = '{4'b0001, 4'b0001, 32'h0000_0011, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'h11, 1'b1};
    vt[6] = '{4'b0001, 4'b0001, 32'h0000_0011, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h11, 1'b1};
    vt[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

    do_reset();
    exp_q.push_back('{2, 8'hA5});
    exp_q.push_back('{2, 8'h5A});
    exp_q.push_back('{0, 8'h11});
    for (int r = 0; r < 8; r++) begin
      @(posedge clk);
      #1;
      req_valid = vt[r].valid;
      req_last  = vt[r].last;
      req_data  = vt[r].data;
      tx_ready  = vt[r].txr;
      @(negedge clk);
      sb_sample();
      check("tbl_grant", grant, vt[r].e_grant);
      check("tbl_ready", req_ready, vt[r].e_ready);
      check("tbl_txv", tx_valid, vt[r].e_txv);
      check("tbl_txd", tx_data, vt[r].e_txd);
      check("tbl_busy", busy, vt[r].e_busy);
    end
    check("tbl_beats_left", exp_q.size(), 0);

    // Round-robin order 0,1,2,3,0 with 3-byte packets and one idle cycle between.
    do_reset();
    load_pkt(0, 8'h10, 3, 1'b1);
    load_pkt(1, 8'h20, 3, 1'b1);
    load_pkt(2, 8'h30, 3, 1'b1);
    load_pkt(3, 8'h40, 3, 1'b1);
    load_pkt(0, 8'h50, 3, 1'b1);
    drive();
    for (int i = 0; i < 20; i++) begin
      cycle();
      exp_g = (i % 4 == 0) ? 4'b0000 : 4'(1 << ((i / 4) % 4));
      check("rr_grant", g_s, exp_g);
      check("rr_ready", r_s, exp_g);
      check("rr_busy", b_s, (i % 4 != 0));
    end
    check("rr_beats_left", exp_q.size(), 0);

    // Timeout: requester 1 stalls after its first byte, requester 3 takes over.
    do_reset();
    load_pkt(1, 8'h31, 3, 1'b0);
    load_pkt(3, 8'h71, 1, 1'b0);
    exp_q.push_back('{1, 8'h31});
    exp_q.push_back('{3, 8'h71});
    exp_q.push_back('{1, 8'h32});
    exp_q.push_back('{1, 8'h33});
    drive();
    cycle();
    stall[1] = 1'b1;
    cycle();
    for (int i = 0; i < T; i++) begin
      cycle();
      check("to_hold", g_s, 4'b0010);
    end
    cycle();
    check("to_release", g_s, 4'b0000);
    cycle();
    check("to_next_owner", g_s, 4'b1000);
    stall[1] = 1'b0;
    drain(30);

    // Near-timeout gaps of T-1 cycles twice: grant must survive both.
    do_reset();
    load_pkt(0, 8'h01, 3, 1'b1);
    drive();
    cycle();
    for (int d = 0; d < 2; d++) begin
      stall[0] = 1'b1;
      cycle();
      for (int i = 0; i < T - 1; i++) begin
        if (i == T - 2) stall[0] = 1'b0;
        cycle();
        check("gap_hold", g_s, 4'b0001);
      end
    end
    cycle();
    check("gap_last_owner", g_s, 4'b0001);
    cycle();
    check("gap_released", g_s, 4'b0000);
    check("gap_beats_left", exp_q.size(), 0);

    // Reset in the middle of requester 3's packet.
    do_reset();
    load_pkt(3, 8'h81, 3, 1'b1);
    drive();
    cycle();
    cycle();
    #1;
    check("mid_grant", grant, 4'b1000);
    check("mid_txd", tx_data, 8'h82);
    #1;
    rst = 1'b1;
    #1;
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_txv", tx_valid, 0);
    check("arst_txd", tx_data, 0);
    check("arst_ready", req_ready, 0);
    clear_bench();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) load_pkt(k, 8'(8'h90 + 8'(k * 16)), 1, 1'b1);
    drive();
    cycle();
    cycle();
    check("arst_first_win", g_s, 4'b0001);
    drain(30);

    // Back-to-back single-byte packets from requester 1 alone.
    do_reset();
    for (int p = 0; p < 4; p++) load_pkt(1, 8'(8'hC0 + 8'(p)), 1, 1'b1);
    drive();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("b2b_busy", b_s, (i % 2 == 1));
      check("b2b_grant", g_s, (i % 2 == 1) ? 4'b0010 : 4'b0000);
    end
    check("b2b_beats_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter P_REQ_NUM, default 4, number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter P_UART_DATA_WIDTH, default 8, byte width of every data port.
REQ-003 Parameter P_TIMEOUT_CYCLE, default 1024, idle-cycle limit before a held grant is revoked (>=2).
REQ-004 i_sys_clk  input  1  single clock for all logic.
REQ-005 i_sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req_data  input  P_REQ_NUM*P_UART_DATA_WIDTH  requester bytes, requester k at slice [k*W +: W].
REQ-007 i_req_valid  input  P_REQ_NUM  per-requester byte valid.
REQ-008 i_req_last  input  P_REQ_NUM  per-requester last-byte-of-packet flag, qualified by valid.
REQ-009 o_req_ready  output  P_REQ_NUM  per-requester byte accepted this cycle.
REQ-010 o_tx_data  output  P_UART_DATA_WIDTH  byte to UART transmitter.
REQ-011 o_tx_valid  output  1  byte valid to UART transmitter.
REQ-012 i_tx_ready  input  1  UART transmitter ready.
REQ-013 o_grant  output  P_REQ_NUM  one-hot current owner, all-zero when idle.
REQ-014 o_busy  output  1  high while any requester owns the transmitter.

Function
REQ-015 FSM has exactly two states: IDLE (no owner) and XFER (one owner, o_grant one-hot).
REQ-016 IDLE: when any i_req_valid bit is high, the winner is registered into o_grant and state moves to XFER on the next edge; no byte is transferred in the IDLE cycle.
REQ-017 Arbitration is round-robin: search starts at (last_owner+1) mod P_REQ_NUM and wraps; last_owner resets to P_REQ_NUM-1 so requester 0 wins first.
REQ-018 XFER: o_tx_data = owner's data, o_tx_valid = owner's i_req_valid, o_req_ready[owner] = i_tx_ready, all combinational; non-owner ready bits stay 0.
REQ-019 A beat occurs when o_tx_valid and i_tx_ready are both high; beats are never dropped or duplicated.
REQ-020 Beat with owner's i_req_last high: next edge returns to IDLE, o_grant cleared, last_owner updated to that owner.
REQ-021 Grant is held across packet bytes; other requesters' valid is ignored until release.
REQ-022 Timeout counter counts consecutive XFER cycles with owner valid low; cleared on any owner-valid-high cycle and on entry to XFER.
REQ-023 Counter reaching P_TIMEOUT_CYCLE-1 with owner valid still low: release grant as in REQ-020 on the next edge.
REQ-024 Beat with last and timeout expiry in the same cycle: beat completes, release happens once.
REQ-025 In IDLE o_tx_valid=0, o_tx_data=0, o_req_ready=0.
REQ-026 o_busy equals (state == XFER).
REQ-027 After release, re-arbitration takes one IDLE cycle; minimum gap between two packets is one cycle.

Reset
REQ-028 i_sys_rst high asynchronously forces IDLE, o_grant=0, o_busy=0, o_tx_valid=0, o_tx_data=0, o_req_ready=0, timeout counter=0, last_owner=P_REQ_NUM-1.
REQ-029 Reset mid-packet abandons the packet; after release the next arbitration follows REQ-017 from reset state.

Verification
REQ-030 Reset, all four valid high with 3-byte packets, i_tx_ready=1 -> grants in order 0,1,2,3,0; each packet 3 beats; one idle cycle between packets.
REQ-031 Requester 2 sends 0xA5,0x5A(last) while i_tx_ready toggles 1,0,1,0 -> exactly two beats on o_tx_data, o_req_ready[2] mirrors i_tx_ready, o_grant=4'b0100 throughout.
REQ-032 Requester 1 owns, drops valid after first byte for P_TIMEOUT_CYCLE cycles -> o_grant cleared exactly P_TIMEOUT_CYCLE cycles after valid falls; requester 3 waiting then wins.
REQ-033 Requester 0 drops valid for P_TIMEOUT_CYCLE-1 cycles then resumes -> no release, counter restarts, packet completes.
REQ-034 Assert i_sys_rst during second byte of requester 3's packet -> all outputs 0 same cycle; after deassert with all valid high requester 0 wins.
REQ-035 Only requester 1 active, back-to-back single-byte packets (last=1) -> requester 1 regranted every second cycle, o_busy toggles 1,0.
